cp_remove_s2p_fft16: RTL and testbench
======================================

Name: cp_remove_s2p_fft16

Overview:
Receive-side front end that sits directly upstream of the 16-point FFT. It takes a serial stream of complex baseband samples, strips the cyclic prefix of each OFDM symbol and collects the 16 useful samples into a ping-pong buffer. Each completed symbol is presented as a parallel 16-word frame with a one-cycle valid pulse, which drives the FFT's i_valid_mapper_control_fft16 / i_fft16 inputs. Back-pressure from the FFT is absorbed by the two buffers and then propagated upstream through o_ready_sample.

Parameters:
DATA_WIDTH, 16, width of the real part and of the imaginary part.
DOUBLE_DATA_WIDTH, 2*DATA_WIDTH, packed complex word: real in [DOUBLE_DATA_WIDTH-1:DATA_WIDTH], imaginary in [DATA_WIDTH-1:0].
N_FFT, 16, useful samples per symbol (fixed at 16).
CP_LEN, 4, cyclic-prefix samples discarded per symbol. Legal range 0..15.

Ports:
i_clk_cprm  in  1  clock.
i_rst_n  in  1  reset, synchronous, active-high. Despite the port name, 1 means reset.
i_valid_sample  in  1  i_sample is valid this cycle.
i_sample  in  DOUBLE_DATA_WIDTH (signed)  complex input sample.
i_sof  in  1  start of symbol; qualified by i_valid_sample. The sample carrying i_sof is CP sample 0.
i_fft_ready  in  1  FFT can accept a new frame (idle / done).
o_ready_sample  out  1  block accepts a sample this cycle.
o_frame  out  DOUBLE_DATA_WIDTH x [15:0] (signed)  parallel symbol; index 0 is the first post-CP sample.
o_valid_frame  out  1  one-cycle pulse; o_frame is new this cycle.
o_sync_err  out  1  one-cycle pulse; i_sof arrived mid-symbol.
o_frame_cnt  out  8  count of frames delivered, wraps 255 -> 0.

Behaviour:
- Reset values: o_frame all 0, o_valid_frame 0, o_sync_err 0, o_frame_cnt 0, o_ready_sample 1. Both buffers are marked empty, the write and read pointers are 0, and the FSM enters IDLE. Reset mid-frame discards all partial and pending data.
- Accept condition: accept = i_valid_sample & o_ready_sample. o_ready_sample = !(state==COLLECT & full[wr_ptr]); it is combinational from registered state only.
- FSM states and transitions:
  - IDLE: accepted samples without i_sof are dropped. An accepted sample with i_sof goes to SKIP_CP with cp_cnt=1, or directly to COLLECT with the sample written at index 0 if CP_LEN=0.
  - SKIP_CP: each accepted sample increments cp_cnt and is discarded. The sample that makes cp_cnt reach CP_LEN leads to COLLECT with idx=0.
  - COLLECT: an accepted sample is written to buf[wr_ptr][idx] and idx increments. On idx=15: full[wr_ptr]<=1, wr_ptr toggles, and the FSM moves to SKIP_CP with cp_cnt=0 (continuous symbols need no further i_sof). With CP_LEN=0 it stays in COLLECT with idx=0.
- i_sof while in SKIP_CP or COLLECT with a nonzero count:
  - Restart the symbol: the partial fill is discarded (buffer not marked full) and o_sync_err pulses next cycle.
  - The i_sof sample is treated as CP sample 0, same as from IDLE.
  - i_sof exactly on the first sample of a new symbol (cp_cnt=0 in SKIP_CP) is normal: no error.
- Handoff:
  - Condition: full[rd_ptr] & i_fft_ready.
  - At that clock edge: o_frame <= buf[rd_ptr], o_valid_frame <= 1, full[rd_ptr] <= 0, rd_ptr toggles, o_frame_cnt increments.
  - o_valid_frame is 0 in all other cycles. o_frame holds its value between handoffs.
- Latency:
  - The 16th useful sample is accepted at edge t. With i_fft_ready=1 and no older frame pending, o_valid_frame is high in the cycle after edge t+1.
  - Handoffs occur at most once per cycle, in order.
- Simultaneous events:
  - A buffer completing fill on the same edge as the other buffer's handoff: both take effect.
  - A handoff freeing the buffer that wr_ptr points at: o_ready_sample rises the next cycle.
- Full: with both buffers full and in COLLECT, o_ready_sample=0 and the sample is held upstream; no sample is lost. During SKIP_CP, samples are always accepted (discarded) even when both buffers are full.
- Widths: no arithmetic is applied to samples; they pass bit-exact. cp_cnt is 4 bits and idx is 4 bits.

Test Plan:
1. Reset, then 20 samples with values 0..19 (real=k, imag=-k), i_sof on sample 0, i_fft_ready=1 -> one o_valid_frame pulse 1 cycle after sample 19; o_frame[0]=(4,-4) ... o_frame[15]=(19,-19); o_frame_cnt=1.
2. 3 back-to-back symbols of 20 samples each, i_sof only on the first, i_fft_ready=1 -> 3 pulses spaced 20 cycles apart; frame 2 index 0 equals input sample 24; o_frame_cnt=3; o_sync_err never asserted.
3. i_fft_ready=0, continuous valid input for 3 symbols -> 2 frames buffered; o_ready_sample drops at the first COLLECT sample of symbol 3. Raise i_fft_ready -> frames 1 and 2 delivered on consecutive cycles, then ready rises and symbol 3 completes with no lost samples.
4. i_sof re-asserted at useful index 7 of symbol 1 -> o_sync_err pulses once; no frame is emitted for the broken symbol; the next frame contains the 16 samples following 4 CP samples after the new i_sof.
5. Samples before any i_sof, plus i_valid_sample gaps (1 of every 3 cycles) -> pre-sof samples ignored; frame content is identical to scenario 1; the pulse comes 1 cycle after the last accepted sample.
6. Reset asserted at useful index 10 with one frame pending -> no o_valid_frame; all outputs return to reset values; after a new i_sof, normal operation resumes with o_frame_cnt counting from 0.

Source files
------------

// File: rtl/cp_remove_s2p_fft16.sv
// Strips the cyclic prefix from a serial OFDM sample stream and hands each set of
// 16 useful samples to the FFT as one parallel frame, through a two-buffer ping-pong.
`timescale 1ns/1ps
module cp_remove_s2p_fft16 #(
   parameter int DATA_WIDTH        = 16,
   parameter int DOUBLE_DATA_WIDTH = 2*DATA_WIDTH,
   parameter int N_FFT             = 16,
   parameter int CP_LEN            = 4
) (
   input  logic                                   i_clk_cprm,
   input  logic                                   i_rst_n,
   input  logic                                   i_valid_sample,
   input  logic signed [DOUBLE_DATA_WIDTH-1:0]    i_sample,
   input  logic                                   i_sof,
   input  logic                                   i_fft_ready,
   output logic                                   o_ready_sample,
   output logic [N_FFT-1:0][DOUBLE_DATA_WIDTH-1:0] o_frame,
   output logic                                   o_valid_frame,
   output logic                                   o_sync_err,
   output logic [7:0]                             o_frame_cnt,
   output logic [1:0]                             o_dbg_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SKIP    = 2'd1;
   localparam logic [1:0] ST_COLLECT = 2'd2;

   localparam logic [3:0] CP_LAST  = 4'(CP_LEN);
   localparam logic [3:0] LAST_IDX = 4'(N_FFT-1);

   logic [1:0] r_state;
   logic [3:0] r_cp_cnt;
   logic [3:0] r_idx;
   logic [1:0] r_full;
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [N_FFT-1:0][DOUBLE_DATA_WIDTH-1:0] r_buf [2];

   logic [1:0] w_state_nxt;
   logic [3:0] w_cp_nxt;
   logic [3:0] w_idx_nxt;
   logic       w_wr_en;
   logic [3:0] w_wr_idx;
   logic       w_fill_done;
   logic       w_accept;
   logic       w_sof_start;
   logic       w_sof_err;
   logic       w_handoff;

   // Upstream handshake: a sample moves when i_valid_sample and o_ready_sample are
   // both high at a rising edge; the source holds sample and i_sof until then.
   assign o_ready_sample = !(r_state == ST_COLLECT && r_full[r_wr_ptr]);
   assign w_accept       = i_valid_sample & o_ready_sample;
   assign w_sof_start    = w_accept & i_sof;
   assign w_handoff      = r_full[r_rd_ptr] & i_fft_ready;
   assign o_dbg_state    = r_state;

   // An i_sof on the natural first sample of a symbol is not an error.
   assign w_sof_err = w_sof_start &
                      ((r_state == ST_SKIP && r_cp_cnt != 4'd0) ||
                       (r_state == ST_COLLECT && !(CP_LEN == 0 && r_idx == 4'd0)));

   always_comb begin
      w_state_nxt = r_state;
      w_cp_nxt    = r_cp_cnt;
      w_idx_nxt   = r_idx;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_idx;
      w_fill_done = 1'b0;
      if (w_sof_start) begin
         // Every i_sof (re)starts a symbol with this sample as CP sample 0.
         if (CP_LEN == 0) begin
            w_state_nxt = ST_COLLECT;
            w_wr_en     = 1'b1;
            w_wr_idx    = 4'd0;
            w_idx_nxt   = 4'd1;
            w_cp_nxt    = 4'd0;
         end else if (CP_LAST == 4'd1) begin
            w_state_nxt = ST_COLLECT;
            w_idx_nxt   = 4'd0;
            w_cp_nxt    = 4'd0;
         end else begin
            w_state_nxt = ST_SKIP;
            w_cp_nxt    = 4'd1;
            w_idx_nxt   = 4'd0;
         end
      end else if (w_accept) begin
         case (r_state)
            ST_SKIP: begin
               if (r_cp_cnt + 4'd1 == CP_LAST) begin
                  w_state_nxt = ST_COLLECT;
                  w_cp_nxt    = 4'd0;
                  w_idx_nxt   = 4'd0;
               end else begin
                  w_cp_nxt = r_cp_cnt + 4'd1;
               end
            end
            ST_COLLECT: begin
               w_wr_en = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_fill_done = 1'b1;
                  w_idx_nxt   = 4'd0;
                  w_cp_nxt    = 4'd0;
                  w_state_nxt = (CP_LEN == 0) ? ST_COLLECT : ST_SKIP;
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Sample storage carries no reset; the full flags alone decide what is valid.
   always_ff @(posedge i_clk_cprm) begin
      if (w_wr_en) begin
         r_buf[r_wr_ptr][w_wr_idx] <= i_sample;
      end
   end

   always_ff @(posedge i_clk_cprm) begin
      if (i_rst_n) begin
         r_state       <= ST_IDLE;
         r_cp_cnt      <= 4'd0;
         r_idx         <= 4'd0;
         r_full        <= 2'b00;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         o_frame       <= '0;
         o_valid_frame <= 1'b0;
         o_sync_err    <= 1'b0;
         o_frame_cnt   <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cp_cnt   <= w_cp_nxt;
         r_idx      <= w_idx_nxt;
         o_sync_err <= w_sof_err;
         // Fill and handoff never target the same buffer, so both may apply at once.
         for (int b = 0; b < 2; b++) begin
            if (w_fill_done && r_wr_ptr == 1'(b)) begin
               r_full[b] <= 1'b1;
            end else if (w_handoff && r_rd_ptr == 1'(b)) begin
               r_full[b] <= 1'b0;
            end
         end
         if (w_fill_done) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         o_valid_frame <= w_handoff;
         if (w_handoff) begin
            o_frame     <= r_buf[r_rd_ptr];
            r_rd_ptr    <= ~r_rd_ptr;
            o_frame_cnt <= o_frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cp_remove_s2p_fft16.sv
// Directed bench for cp_remove_s2p_fft16: a cycle table for the basic symbol and
// hand-written sequences for streaming, back-pressure, resync, gaps and reset.
`timescale 1ns/1ps
module tb_cp_remove_s2p_fft16;
  localparam int DW  = 16;
  localparam int DDW = 32;
  localparam int NF  = 16;

  typedef logic [NF-1:0][DDW-1:0] frame_t;
  typedef struct {
    logic vld;
    logic sof;
    int   k;
    logic exp_vf;
    logic exp_rdy;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           vld;
  logic [DDW-1:0] smp;
  logic           sof;
  logic           fft_rdy;
  logic           o_ready_sample;
  frame_t         o_frame;
  logic           o_valid_frame;
  logic           o_sync_err;
  logic [7:0]     o_frame_cnt;
  logic [1:0]     o_dbg_state;

  cp_remove_s2p_fft16 dut (
    .i_clk_cprm     (clk),
    .i_rst_n        (rst),
    .i_valid_sample (vld),
    .i_sample       (smp),
    .i_sof          (sof),
    .i_fft_ready    (fft_rdy),
    .o_ready_sample (o_ready_sample),
    .o_frame        (o_frame),
    .o_valid_frame  (o_valid_frame),
    .o_sync_err     (o_sync_err),
    .o_frame_cnt    (o_frame_cnt),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame / error monitor, sampled on the falling edge
  frame_t cap_q[$];
  int     cap_cyc[$];
  int     n_sync = 0;
  always @(negedge clk) begin
    if (o_valid_frame) begin
      cap_q.push_back(o_frame);
      cap_cyc.push_back(cyc);
    end
    if (o_sync_err) n_sync++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_acc = 0;
  int first_stall_k = -1;
  int release_after = -1;
  int rel_cyc = 0;
  vec_t tbl [22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared / %0d bad", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DDW-1:0] mk(input int k);
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    re = DW'(k);
    im = DW'(-k);
    return {re, im};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input frame_t f, input int base);
    for (int i = 0; i < NF; i++)
      chk($sformatf("%s[%0d]", nm, i), f[i], mk(base + i));
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; sof = 1'b0; smp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
    cap_cyc.delete();
    n_sync = 0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0; sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k, input logic s);
    int stall;
    vld = 1'b1; smp = mk(k); sof = s; stall = 0;
    while (!o_ready_sample) begin
      if (first_stall_k < 0) first_stall_k = k;
      if (stall == release_after && !fft_rdy) begin
        fft_rdy = 1'b1;
        rel_cyc = cyc;
      end
      @(posedge clk); #1;
      stall++;
      if (stall > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", k, stall);
        vld = 1'b0; sof = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    last_acc = cyc;
    vld = 1'b0; sof = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sof = 1'b0; smp = '0; fft_rdy = 1'b1;

    for (int r = 0; r < 20; r++) tbl[r] = '{vld: 1'b1, sof: (r == 0), k: r, exp_vf: 1'b0, exp_rdy: 1'b1};
    tbl[20] = '{vld: 1'b0, sof: 1'b0, k: 0, exp_vf: 1'b1, exp_rdy: 1'b1};
    tbl[21] = '{vld: 1'b0, sof: 1'b0, k: 0, exp_vf: 1'b0, exp_rdy: 1'b1};

    // 1: reset values, then one symbol driven from the table
    do_reset();
    chk("rst_ready", 32'(o_ready_sample), 32'd1);
    chk("rst_valid_frame", 32'(o_valid_frame), 32'd0);
    chk("rst_sync_err", 32'(o_sync_err), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_frame_zero", 32'(o_frame == '0), 32'd1);
    chk("rst_state_idle", 32'(o_dbg_state), 32'd0);
    for (int r = 0; r < 22; r++) begin
      vld = tbl[r].vld; sof = tbl[r].sof; smp = mk(tbl[r].k);
      chk($sformatf("s1_ready_row%0d", r), 32'(o_ready_sample), 32'(tbl[r].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("s1_vf_row%0d", r), 32'(o_valid_frame), 32'(tbl[r].exp_vf));
    end
    vld = 1'b0; sof = 1'b0;
    chk("s1_nframes", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() >= 1) chk_frame("s1_frame", cap_q[0], 4);
    chk("s1_frame_cnt", 32'(o_frame_cnt), 32'd1);
    chk("s1_sync", 32'(n_sync), 32'd0);

    // 2: three back-to-back symbols, i_sof only on the first
    do_reset();
    fft_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send(k, k == 0);
      if (k == 19) rel_cyc = last_acc;
    end
    idle(3);
    chk("s2_nframes", 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      for (int f = 0; f < 3; f++) chk_frame($sformatf("s2_frame%0d", f), cap_q[f], 20*f + 4);
      chk("s2_frame2_idx0", cap_q[1][0], mk(24));
      chk("s2_latency", 32'(cap_cyc[0]), 32'(rel_cyc + 1));
      chk("s2_spacing1", 32'(cap_cyc[1] - cap_cyc[0]), 32'd20);
      chk("s2_spacing2", 32'(cap_cyc[2] - cap_cyc[1]), 32'd20);
    end
    chk("s2_frame_cnt", 32'(o_frame_cnt), 32'd3);
    chk("s2_sync", 32'(n_sync), 32'd0);

    // 3: FFT stalled for three symbols, then released
    do_reset();
    fft_rdy = 1'b0; first_stall_k = -1; release_after = 5;
    for (int k = 0; k < 60; k++) send(k, k == 0);
    idle(3);
    release_after = -1;
    chk("s3_first_stall_k", 32'(first_stall_k), 32'd44);
    chk("s3_nframes", 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      chk("s3_release_latency", 32'(cap_cyc[0]), 32'(rel_cyc + 1));
      chk("s3_consecutive", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
      for (int f = 0; f < 3; f++) chk_frame($sformatf("s3_frame%0d", f), cap_q[f], 20*f + 4);
    end
    chk("s3_frame_cnt", 32'(o_frame_cnt), 32'd3);

    // 4: i_sof again at useful index 7
    do_reset();
    fft_rdy = 1'b1;
    for (int k = 0; k <= 10; k++) send(k, k == 0);
    send(100, 1'b1);
    for (int k = 101; k < 120; k++) send(k, 1'b0);
    idle(3);
    chk("s4_sync_pulses", 32'(n_sync), 32'd1);
    chk("s4_nframes", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() == 1) chk_frame("s4_frame", cap_q[0], 104);
    chk("s4_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // 5: pre-sof samples and 1-in-3 valid gaps
    do_reset();
    for (int k = 200; k < 205; k++) begin send(k, 1'b0); idle(2); end
    for (int k = 0; k < 20; k++) begin
      send(k, k == 0);
      if (k != 19) idle(2);
    end
    rel_cyc = last_acc;
    idle(3);
    chk("s5_nframes", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() == 1) begin
      chk_frame("s5_frame", cap_q[0], 4);
      chk("s5_latency", 32'(cap_cyc[0]), 32'(rel_cyc + 1));
    end
    chk("s5_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // 6: reset mid-symbol with a frame pending
    do_reset();
    fft_rdy = 1'b0;
    for (int k = 0; k < 34; k++) send(k, k == 0);
    chk("s6_pending_no_frame", 32'(cap_q.size()), 32'd0);
    vld = 1'b1; smp = mk(34); rst = 1'b1; fft_rdy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("s6_rst_valid_frame", 32'(o_valid_frame), 32'd0);
    chk("s6_rst_ready", 32'(o_ready_sample), 32'd1);
    chk("s6_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("s6_rst_frame_zero", 32'(o_frame == '0), 32'd1);
    chk("s6_rst_state_idle", 32'(o_dbg_state), 32'd0);
    rst = 1'b0;
    idle(3);
    chk("s6_no_stale_frame", 32'(cap_q.size()), 32'd0);
    for (int k = 300; k < 320; k++) send(k, k == 300);
    idle(3);
    chk("s6_nframes", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() == 1) chk_frame("s6_frame", cap_q[0], 304);
    chk("s6_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
